// File: rtl/forwarding_hazard_unit.sv
// Youngest-match forwarding selects (registered, 1 cycle) and load-use stall (combinational) for the ID/EX boundary.
// No handshake: stall holds IF/ID and bubbles EX; flush squashes ID and EX and overrides stall.
module forwarding_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel_1,
    output logic [SEL_W-1:0]  fwd_sel_2,
    output logic [CNT_W-1:0]  stall_count
);

    if (LOAD_LAT < 0 || LOAD_LAT >= FWD_STAGES) begin : g_bad_load_lat
        $error("forwarding_hazard_unit: LOAD_LAT must be in 0..FWD_STAGES-1");
    end

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } trk_t;

    trk_t             trk [1:FWD_STAGES];
    trk_t             squash_in;
    logic [SEL_W-1:0] sel_1_nxt;
    logic [SEL_W-1:0] sel_2_nxt;
    logic             load_hit_1;
    logic             load_hit_2;
    logic             adv;

    // Scan oldest to youngest so the smallest k overwrites and wins.
    always_comb begin
        sel_1_nxt  = '0;
        sel_2_nxt  = '0;
        load_hit_1 = 1'b0;
        load_hit_2 = 1'b0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (trk[k].valid && trk[k].we && trk[k].rd == id_rs1 &&
                id_rs1 != '0 && id_rs1_used) begin
                sel_1_nxt  = SEL_W'(k);
                load_hit_1 = trk[k].is_load && (k <= LOAD_LAT);
            end
            if (trk[k].valid && trk[k].we && trk[k].rd == id_rs2 &&
                id_rs2 != '0 && id_rs2_used) begin
                sel_2_nxt  = SEL_W'(k);
                load_hit_2 = trk[k].is_load && (k <= LOAD_LAT);
            end
        end
    end

    always_comb begin
        stall     = id_valid && !flush && (load_hit_1 || load_hit_2);
        adv       = id_valid && !stall && !flush;
        squash_in = trk[1];
        if (flush) begin
            squash_in.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= FWD_STAGES; k++) begin
                trk[k] <= '0;
            end
            fwd_sel_1   <= '0;
            fwd_sel_2   <= '0;
            stall_count <= '0;
        end else begin
            trk[1] <= adv ? trk_t'{valid: 1'b1, rd: id_rd, we: id_we, is_load: id_is_load} : '0;
            // The entry leaving trk[1] is the instruction in EX, which flush kills.
            for (int k = 2; k <= FWD_STAGES; k++) begin
                trk[k] <= (k == 2) ? squash_in : trk[k-1];
            end
            fwd_sel_1 <= adv ? sel_1_nxt : '0;
            fwd_sel_2 <= adv ? sel_2_nxt : '0;
            if (stall && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench: dut (defaults), dut3 (FWD_STAGES=3) and dut4 (CNT_W=4) share one stimulus stream.
module tb_forwarding_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_we;
    logic       id_is_load;
    logic       flush;

    logic        stall,   stall3,   stall4;
    logic [1:0]  sel1,    sel2,     sel1_3,  sel2_3, sel1_4, sel2_4;
    logic [15:0] cnt,     cnt3;
    logic [3:0]  cnt4;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    forwarding_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_sel_1(sel1),
        .fwd_sel_2(sel2), .stall_count(cnt)
    );

    forwarding_hazard_unit #(.FWD_STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .stall(stall3), .fwd_sel_1(sel1_3),
        .fwd_sel_2(sel2_3), .stall_count(cnt3)
    );

    forwarding_hazard_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .stall(stall4), .fwd_sel_1(sel1_4),
        .fwd_sel_2(sel2_4), .stall_count(cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_we       = we;
        id_is_load  = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        flush = 1'b0;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%0b want=0", stall); else passed++;
        total++; if (sel1 !== 2'd0 || sel2 !== 2'd0) $display("FAIL reset_sel got=%0d/%0d want=0/0", sel1, sel2); else passed++;
        total++; if (cnt !== 16'd0) $display("FAIL reset_count got=%0d want=0", cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
        total++; if (stall !== 1'b0) $display("FAIL b2b_stall got=%0b want=0", stall); else passed++;
        tick();
        idle();
        total++; if (sel1 !== 2'd1) $display("FAIL b2b_sel1 got=%0d want=1", sel1); else passed++;
        total++; if (sel2 !== 2'd1) $display("FAIL b2b_sel2 got=%0d want=1", sel2); else passed++;
    endtask

    task automatic test_gap();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);   // nop
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);   // sub x7,x5,x1
        tick();
        idle();
        total++; if (sel1 !== 2'd2) $display("FAIL gap1_sel1 got=%0d want=2", sel1); else passed++;
        total++; if (sel2 !== 2'd0) $display("FAIL gap1_sel2 got=%0d want=0", sel2); else passed++;
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        idle();
        total++; if (sel1_3 !== 2'd3) $display("FAIL gap2_sel1_fwd3 got=%0d want=3", sel1_3); else passed++;
        total++; if (sel1 !== 2'd0) $display("FAIL gap2_sel1_fwd2 got=%0d want=0", sel1); else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x0
        total++; if (stall !== 1'b1) $display("FAIL lu_stall_on got=%0b want=1", stall); else passed++;
        tick();
        total++; if (stall !== 1'b0) $display("FAIL lu_stall_off got=%0b want=0", stall); else passed++;
        total++; if (cnt !== 16'd1) $display("FAIL lu_count got=%0d want=1", cnt); else passed++;
        total++; if (sel1 !== 2'd0) $display("FAIL lu_bubble_sel got=%0d want=0", sel1); else passed++;
        tick();
        idle();
        total++; if (sel1 !== 2'd2 || sel2 !== 2'd0) $display("FAIL lu_sel got=%0d/%0d want=2/0", sel1, sel2); else passed++;
        total++; if (cnt !== 16'd1) $display("FAIL lu_count_hold got=%0d want=1", cnt); else passed++;
    endtask

    task automatic test_youngest_and_x0();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5
        tick();
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);   // add x8,x5,x5
        tick();
        total++; if (sel1 !== 2'd1 || sel2 !== 2'd1) $display("FAIL young_sel got=%0d/%0d want=1/1", sel1, sel2); else passed++;
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0 (writes x0)
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x0,x0
        total++; if (stall !== 1'b0) $display("FAIL x0_stall got=%0b want=0", stall); else passed++;
        tick();
        idle();
        total++; if (sel1 !== 2'd0 || sel2 !== 2'd0) $display("FAIL x0_sel got=%0d/%0d want=0/0", sel1, sel2); else passed++;
        // a younger ALU write of x5 shadows an older load of x5
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5 (gets to k=2)
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        total++; if (stall !== 1'b0) $display("FAIL shadow_stall got=%0b want=0", stall); else passed++;
        tick();
        idle();
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL flush_stall got=%0b want=0", stall); else passed++;
        tick();
        flush = 1'b0;
        total++; if (sel1 !== 2'd0 || sel2 !== 2'd0) $display("FAIL flush_sel got=%0d/%0d want=0/0", sel1, sel2); else passed++;
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);   // squashed lw must not be seen
        total++; if (stall !== 1'b0) $display("FAIL flush_squash_stall got=%0b want=0", stall); else passed++;
        tick();
        idle();
        total++; if (sel1 !== 2'd0) $display("FAIL flush_squash_sel got=%0d want=0", sel1); else passed++;
        total++; if (cnt !== 16'd0) $display("FAIL flush_count got=%0d want=0", cnt); else passed++;
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        total++; if (stall !== 1'b1) $display("FAIL midrst_stall_on got=%0b want=1", stall); else passed++;
        rst_n = 1'b0;
        tick();
        total++; if (stall !== 1'b0) $display("FAIL midrst_stall got=%0b want=0", stall); else passed++;
        total++; if (cnt !== 16'd0) $display("FAIL midrst_count got=%0d want=0", cnt); else passed++;
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
            tick();
            tick();
        end
        idle();
        tick();
        total++; if (cnt4 !== 4'd15) $display("FAIL sat_count4 got=%0d want=15", cnt4); else passed++;
        total++; if (cnt !== 16'd20) $display("FAIL sat_count16 got=%0d want=20", cnt); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_gap();
        test_load_use();
        test_youngest_and_x0();
        test_flush_and_reset();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
